// File: rtl/a_b_req_arbiter_if.sv
// Requester-side and A/B bus-side signals of the arbiter bundled as one interface.
// The arbiter takes the master modport; the environment driving requests and observing the bus takes slave.
interface a_b_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DATA_W  = 24
);
    localparam int unsigned ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      Valid_Addr;
    logic [ADDR_W-1:0]         Address;
    logic                      Valid_Data;
    logic [DATA_W-1:0]         Data;
    logic                      busy;
    logic                      done;
    logic [ID_W-1:0]           done_id;

    modport master (
        input  req_valid, req_addr, req_data,
        output req_ready, Valid_Addr, Address, Valid_Data, Data, busy, done, done_id
    );

    modport slave (
        output req_valid, req_addr, req_data,
        input  req_ready, Valid_Addr, Address, Valid_Data, Data, busy, done, done_id
    );
endinterface

// File: rtl/a_b_req_arbiter.sv
// Round-robin arbiter that grants one requester at a time and drives its address
// phase, then its data phase DATA_GAP cycles later, on the shared A/B request bus.
module a_b_req_arbiter #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 24,
    parameter int unsigned DATA_GAP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    a_b_req_arbiter_if.master bus
);
    localparam int unsigned ID_W  = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = 4;

    if (DATA_GAP < 1 || DATA_GAP > 15) begin : g_bad_gap
        $error("a_b_req_arbiter: DATA_GAP must be within 1..15");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num
        $error("a_b_req_arbiter: NUM_REQ must be within 2..8");
    end

    typedef enum logic [1:0] {IDLE, ADDR, GAP, DATA} state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_grant_q, last_grant_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     done_id_q, done_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   lat_data_q, lat_data_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                valid_addr_q, valid_addr_d;
    logic                valid_data_q, valid_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ID_W-1:0]     idx;
    logic [ID_W-1:0]     winner;
    logic                found;
    logic [NUM_REQ-1:0]  ready;
    logic                accept;

    // First valid requester after last_grant, wrapping
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = ID_W'((32'(last_grant_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign ready  = (state_q == IDLE && found && rst_n) ? (NUM_REQ'(1) << winner) : '0;
    assign accept = |(bus.req_valid & ready);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        done_id_d    = done_id_q;
        cnt_d        = cnt_q;
        lat_data_d   = lat_data_q;
        busy_d       = busy_q;
        valid_addr_d = 1'b0;
        address_d    = '0;
        valid_data_d = 1'b0;
        data_d       = '0;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    last_grant_d = winner;
                    id_d         = winner;
                    lat_data_d   = bus.req_data[32'(winner)*DATA_W +: DATA_W];
                    address_d    = bus.req_addr[32'(winner)*ADDR_W +: ADDR_W];
                    valid_addr_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (DATA_GAP == 1) begin
                    valid_data_d = 1'b1;
                    data_d       = lat_data_q;
                    done_d       = 1'b1;
                    done_id_d    = id_q;
                    state_d      = DATA;
                end else begin
                    cnt_d   = CNT_W'(DATA_GAP - 1);
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_q == CNT_W'(1)) begin
                    valid_data_d = 1'b1;
                    data_d       = lat_data_q;
                    done_d       = 1'b1;
                    done_id_d    = id_q;
                    state_d      = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DATA: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            id_q         <= '0;
            done_id_q    <= '0;
            cnt_q        <= '0;
            lat_data_q   <= '0;
            data_q       <= '0;
            address_q    <= '0;
            valid_addr_q <= 1'b0;
            valid_data_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            done_id_q    <= done_id_d;
            cnt_q        <= cnt_d;
            lat_data_q   <= lat_data_d;
            data_q       <= data_d;
            address_q    <= address_d;
            valid_addr_q <= valid_addr_d;
            valid_data_q <= valid_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign bus.req_ready  = ready;
    assign bus.Valid_Addr = valid_addr_q;
    assign bus.Address    = address_q;
    assign bus.Valid_Data = valid_data_q;
    assign bus.Data       = data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
endmodule

// File: tb/tb_a_b_req_arbiter.sv
// Scoreboard bench: two arbiters (DATA_GAP 1 and 5) share one stimulus stream; a
// transaction-level model predicts every bus phase, and per-cycle monitors compare.
module tb_a_b_req_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ADDR_W  = 12;
    localparam int unsigned DATA_W  = 24;
    localparam int unsigned ID_W    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      end_check = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] val;
        int                id;
    } ev_t;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int g, input int cyc,
                       input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL dut%0d %s cycle %0d: got 0x%0h want 0x%0h", g, name, cyc, got, exp);
        end
    endtask

    // Round-robin choice: first requesting index after p, wrapping; -1 when nobody asks
    function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int j = 1; j <= int'(NUM_REQ); j++) begin
            if (v[(p + j) % NUM_REQ]) return (p + j) % NUM_REQ;
        end
        return -1;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned GAP = (g == 0) ? 1 : 5;

        a_b_req_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

        assign ifc.req_valid = req_valid;
        assign ifc.req_addr  = req_addr;
        assign ifc.req_data  = req_data;

        a_b_req_arbiter #(
            .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DATA_GAP(GAP)
        ) dut (
            .clk  (clk),
            .rst_n(rst_n),
            .bus  (ifc)
        );

        ev_t aq[$];
        ev_t dq[$];
        int  mcyc    = 0;
        int  idle_at = 0;
        int  ptr     = NUM_REQ - 1;
        bit  armed   = 1'b0;
        bit  ended   = 1'b0;

        // Model: accept at cycle c -> address phase c+1, data phase c+1+GAP, free again c+2+GAP
        always @(posedge clk) begin
            int w;
            if (!rst_n) begin
                aq.delete();
                dq.delete();
                ptr     = NUM_REQ - 1;
                idle_at = mcyc + 1;
                armed   = 1'b1;
            end else if (armed && mcyc >= idle_at) begin
                w = pick(req_valid, ptr);
                if (w >= 0) begin
                    aq.push_back('{cyc: mcyc + 1, val: DATA_W'(req_addr[w*ADDR_W +: ADDR_W]), id: w});
                    dq.push_back('{cyc: mcyc + 1 + GAP, val: req_data[w*DATA_W +: DATA_W], id: w});
                    ptr     = w;
                    idle_at = mcyc + 2 + GAP;
                end
            end
            mcyc++;
        end

        always @(negedge clk) begin
            int                w;
            logic [NUM_REQ-1:0] exp_ready;
            bit                exp_va, exp_vd;
            logic [ADDR_W-1:0] exp_addr;
            logic [DATA_W-1:0] exp_data;
            logic [ID_W-1:0]   exp_id;
            if (armed) begin
                w         = pick(req_valid, ptr);
                exp_ready = (rst_n && mcyc >= idle_at && w >= 0) ? NUM_REQ'(1) << w : '0;
                chk("req_ready", g, mcyc, 64'(ifc.req_ready), 64'(exp_ready));
                chk("busy", g, mcyc, 64'(ifc.busy), 64'(mcyc < idle_at));

                exp_va   = (aq.size() > 0) && (aq[0].cyc == mcyc);
                exp_addr = exp_va ? ADDR_W'(aq[0].val) : '0;
                if (exp_va) void'(aq.pop_front());
                chk("addr_phase", g, mcyc, {51'b0, ifc.Valid_Addr, ifc.Address},
                    {51'b0, exp_va, exp_addr});

                exp_vd   = (dq.size() > 0) && (dq[0].cyc == mcyc);
                exp_data = exp_vd ? dq[0].val : '0;
                exp_id   = exp_vd ? ID_W'(dq[0].id) : '0;
                if (exp_vd) void'(dq.pop_front());
                chk("data_phase", g, mcyc,
                    {36'b0, ifc.Valid_Data, ifc.done, ifc.Data, (ifc.done ? ifc.done_id : ID_W'(0))},
                    {36'b0, exp_vd, exp_vd, exp_data, exp_id});

                if (end_check && !ended) begin
                    chk("pending_at_end", g, mcyc, 64'(aq.size() + dq.size()), 64'(0));
                    ended = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_step(input logic [NUM_REQ-1:0] v);
        req_valid = v;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            req_data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        end
        tick();
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        idle(4);

        // Single transfer from requester 0
        req_valid = 4'b0001;
        req_addr[0 +: ADDR_W] = 12'h123;
        req_data[0 +: DATA_W] = 24'hABCDEF;
        tick();
        idle(8);

        // Everyone requesting: strict rotation
        repeat (20) rnd_step(4'b1111);
        idle(8);

        // Wrap and skip
        repeat (6) rnd_step(4'b0100);
        repeat (12) rnd_step(4'b1001);
        idle(8);

        // Long gap with a late request from requester 1
        req_valid = 4'b0001;
        req_addr[0 +: ADDR_W] = 12'hFFF;
        req_data[0 +: DATA_W] = 24'h000001;
        tick();
        repeat (12) rnd_step(4'b0010);
        idle(8);

        // Reset while the slow arbiter sits in its gap
        rnd_step(4'b0001);
        idle(2);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        repeat (10) rnd_step(4'b0011);
        idle(8);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            rst_n = ($urandom_range(0, 79) != 0);
            rnd_step(NUM_REQ'($urandom));
        end
        rst_n = 1'b1;
        idle(20);

        end_check = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
